speed_test_ctrl: RTL and testbench

SPEED_TEST_CTRL -- requirements
Module: speed_test_ctrl

---
 rtl/speed_test_ctrl.sv | 138 +++++++++++++
 tb/tb_speed_test_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/speed_test_ctrl.sv
// speed_test_ctrl: gated rising-edge counter on a selectable GPIO channel with hold and continuous rearm
module speed_test_ctrl #(
    parameter int GATE_LOG2 = 26,
    parameter int HOLD_LOG2 = 26
) (
    input  logic        FPGA_CLK1_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic        cont,
    input  logic [3:0]  sel,
    input  logic [9:0]  GPIO,
    output logic [15:0] result,
    output logic        ovf,
    output logic        busy,
    output logic        done,
    output logic [7:0]  LED
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] GATE = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic                 start_s1, start_s2, start_d, start_ok;
    logic [1:0]           fill;
    logic                 cont_s1, cont_s2;
    logic [9:0]           gpio_s1, gpio_s2;
    logic [1:0]           state;
    logic [3:0]           chan;
    logic                 ch_sync, ch_sync_d, ch_edge;
    logic [15:0]          cnt, cnt_nxt;
    logic                 sat, sat_nxt;
    logic [GATE_LOG2-1:0] gate_tmr;
    logic [HOLD_LOG2-1:0] hold_tmr;
    logic                 start_edge, gate_end, in_gate;

    assign in_gate    = state == GATE;
    assign start_edge = start_s2 & ~start_d & start_ok;
    assign ch_sync    = (chan < 4'd10) ? gpio_s2[chan] : ^gpio_s2;
    assign ch_edge    = ch_sync & ~ch_sync_d;
    assign gate_end   = in_gate & (&gate_tmr);
    assign cnt_nxt    = (in_gate & ch_edge & ~(&cnt)) ? cnt + 16'd1 : cnt;
    assign sat_nxt    = sat | (in_gate & ch_edge & (&cnt));
    assign busy       = (state == ARM) | in_gate;
    assign LED        = {ovf, busy, result[5:0]};

    // two-flop synchronizers for every asynchronous input
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
            cont_s1  <= 1'b0;
            cont_s2  <= 1'b0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_d  <= start_s2;
            cont_s1  <= cont;
            cont_s2  <= cont_s1;
            gpio_s1  <= GPIO;
            gpio_s2  <= gpio_s1;
        end
    end

    // start edges count only after a genuine low level is seen once the synchronizer has refilled
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            fill     <= 2'd0;
            start_ok <= 1'b0;
        end else begin
            fill     <= (fill == 2'd2) ? fill : fill + 2'd1;
            start_ok <= start_ok | ((fill == 2'd2) & ~start_s2);
        end
    end

    // measurement sequencer with gate and hold timers
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gate_tmr <= '0;
            hold_tmr <= '0;
        end else begin
            case (state)
                IDLE: state <= start_edge ? ARM : IDLE;
                ARM: begin
                    state    <= GATE;
                    gate_tmr <= '0;
                end
                GATE: begin
                    gate_tmr <= gate_tmr + 1'b1;
                    hold_tmr <= '0;
                    state    <= (&gate_tmr) ? HOLD : GATE;
                end
                default: begin
                    hold_tmr <= hold_tmr + 1'b1;
                    state    <= (&hold_tmr) ? (cont_s2 ? ARM : IDLE) : HOLD;
                end
            endcase
        end
    end

    // channel latch, edge history and saturating edge counter
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            chan      <= 4'd0;
            ch_sync_d <= 1'b0;
            cnt       <= 16'd0;
            sat       <= 1'b0;
        end else begin
            ch_sync_d <= ch_sync;
            if (state == ARM) begin
                chan <= sel;
                cnt  <= 16'd0;
                sat  <= 1'b0;
            end else if (in_gate) begin
                cnt <= cnt_nxt;
                sat <= sat_nxt;
            end
        end
    end

    // publish the window result, including any edge in the final gate cycle
    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            result <= 16'd0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= gate_end;
            if (gate_end) begin
                result <= cnt_nxt;
                ovf    <= sat_nxt;
            end
        end
    end
endmodule

// File: tb/tb_speed_test_ctrl.sv
// tb_speed_test_ctrl: directed self-checking bench for speed_test_ctrl
module tb_speed_test_ctrl;
    logic        clk = 1'b0;
    logic        reset_n, start, cont;
    logic [3:0]  sel;
    logic [9:0]  gpio;
    logic [15:0] result;
    logic        ovf, busy, done;
    logic [7:0]  led;
    logic        s_start;
    logic [3:0]  s_sel;
    logic [9:0]  s_gpio;
    logic [15:0] s_result;
    logic        s_ovf, s_busy, s_done;
    logic [7:0]  s_led;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    speed_test_ctrl #(.GATE_LOG2(4), .HOLD_LOG2(3)) dut (
        .FPGA_CLK1_50(clk), .reset_n(reset_n), .start(start), .cont(cont), .sel(sel), .GPIO(gpio),
        .result(result), .ovf(ovf), .busy(busy), .done(done), .LED(led)
    );

    speed_test_ctrl #(.GATE_LOG2(7), .HOLD_LOG2(3)) u_sat (
        .FPGA_CLK1_50(clk), .reset_n(reset_n), .start(s_start), .cont(1'b0), .sel(s_sel), .GPIO(s_gpio),
        .result(s_result), .ovf(s_ovf), .busy(s_busy), .done(s_done), .LED(s_led)
    );

    task automatic test_reset();
        #2;
        checks += 6;
        if (result !== 16'd0) begin errors++; $display("FAIL reset_result got=%h want=0000", result); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h want=00", led); end
        if (s_led !== 8'h00) begin errors++; $display("FAIL reset_sat_led got=%h want=00", s_led); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_count();
        int b = -1, nb = 0, nd = 0, di = -1;
        logic [15:0] r = 16'hxxxx;
        logic o = 1'bx;
        logic [7:0] l = 8'hxx;
        sel = 4'd3;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy) begin nb++; if (b < 0) b = i; end
            if (done) begin nd++; di = i; r = result; o = ovf; l = led; end
            start = (i == 0);
            gpio[3] = (b >= 0) && (i - b < 10) && ((i - b) % 2 == 0);
        end
        checks += 8;
        if (b != 3) begin errors++; $display("FAIL count_arm_cycle got=%0d want=3", b); end
        if (nb != 17) begin errors++; $display("FAIL count_busy_cycles got=%0d want=17", nb); end
        if (nd != 1) begin errors++; $display("FAIL count_done_pulses got=%0d want=1", nd); end
        if (di != 20) begin errors++; $display("FAIL count_done_cycle got=%0d want=20", di); end
        if (r !== 16'd5) begin errors++; $display("FAIL count_result got=%0d want=5", r); end
        if (o !== 1'b0) begin errors++; $display("FAIL count_ovf got=%b want=0", o); end
        if (l !== 8'h05) begin errors++; $display("FAIL count_led got=%h want=05", l); end
        if (result !== 16'd5) begin errors++; $display("FAIL count_result_held got=%0d want=5", result); end
    endtask

    task automatic test_cont();
        int nd = 0;
        cont = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (done) begin
                checks += 2;
                if (i != 20 + 25 * nd) begin errors++; $display("FAIL cont_done_cycle got=%0d want=%0d", i, 20 + 25 * nd); end
                if (result !== 16'd0) begin errors++; $display("FAIL cont_result got=%0d want=0", result); end
                nd++;
            end
            start = (i == 0);
            cont = (i < 96);
        end
        checks += 2;
        if (nd != 4) begin errors++; $display("FAIL cont_done_pulses got=%0d want=4", nd); end
        if (busy !== 1'b0) begin errors++; $display("FAIL cont_stops_busy got=%b want=0", busy); end
    endtask

    task automatic test_ignore();
        int b = -1, nb = 0, nd = 0, di = -1;
        logic [15:0] r = 16'hxxxx;
        sel = 4'd3;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) begin nb++; if (b < 0) b = i; end
            if (done) begin nd++; di = i; r = result; end
            start = (i == 0) || (b >= 0 && i - b == 5);
            sel = (b >= 0 && i - b >= 5) ? 4'd5 : 4'd3;
            gpio[3] = (b >= 0) && (i - b < 6) && ((i - b) % 2 == 0);
            gpio[5] = (b >= 0) && (i - b >= 6) && (i - b < 14) && ((i - b) % 2 == 0);
        end
        gpio = '0;
        sel = 4'd3;
        checks += 4;
        if (nd != 1) begin errors++; $display("FAIL ignore_done_pulses got=%0d want=1", nd); end
        if (di != 20) begin errors++; $display("FAIL ignore_done_cycle got=%0d want=20", di); end
        if (r !== 16'd3) begin errors++; $display("FAIL ignore_latched_channel got=%0d want=3", r); end
        if (nb != 17) begin errors++; $display("FAIL ignore_busy_cycles got=%0d want=17", nb); end
    endtask

    task automatic test_reset_abort();
        int b = -1, nb = 0, nd = 0;
        sel = 4'd3;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (busy && b < 0) b = i;
            if (done) nd++;
            start = (i == 0);
            gpio[3] = (b >= 0) && (i - b < 6) && ((i - b) % 2 == 0);
        end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_gate got=%b want=1", busy); end
        if (nd != 0) begin errors++; $display("FAIL abort_early_done got=%0d want=0", nd); end
        reset_n = 1'b0;
        start = 1'b1;
        gpio = '0;
        #1;
        checks += 5;
        if (result !== 16'd0) begin errors++; $display("FAIL abort_result got=%0d want=0", result); end
        if (ovf !== 1'b0) begin errors++; $display("FAIL abort_ovf got=%b want=0", ovf); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
        if (led !== 8'h00) begin errors++; $display("FAIL abort_led got=%h want=00", led); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) nd++;
        end
        checks += 3;
        if (nb != 0) begin errors++; $display("FAIL release_held_start_busy got=%0d want=0", nb); end
        if (nd != 0) begin errors++; $display("FAIL release_done got=%0d want=0", nd); end
        if (result !== 16'd0) begin errors++; $display("FAIL release_result got=%0d want=0", result); end
        start = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_parity();
        int b = -1, nd = 0, ref_cnt = 0;
        logic pp = 1'b0;
        logic [15:0] r = 16'hxxxx;
        sel = 4'd12;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (busy && b < 0) b = i;
            if (done) begin nd++; r = result; end
            start = (i == 0);
            if (b >= 0 && i - b <= 10 && (i - b) % 2 == 0) begin
                if (((i - b) / 2) % 2 == 0) gpio[1] = ~gpio[1];
                else gpio[2] = ~gpio[2];
                if ((^gpio) && !pp) ref_cnt++;
                pp = ^gpio;
            end
        end
        gpio = '0;
        checks += 2;
        if (nd != 1) begin errors++; $display("FAIL parity_done_pulses got=%0d want=1", nd); end
        if (r !== 16'(ref_cnt)) begin errors++; $display("FAIL parity_result got=%0d want=%0d", r, ref_cnt); end
    endtask

    task automatic test_saturate();
        int b = -1, nd = 0;
        logic [15:0] r = 16'hxxxx;
        logic o = 1'bx;
        logic [7:0] l = 8'hxx;
        s_sel = 4'd0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (s_busy && b < 0) b = i;
            if (s_done) begin nd++; r = s_result; o = s_ovf; l = s_led; end
            s_start = (i == 0);
            if (b >= 0 && i - b < 127) s_gpio[0] = ~s_gpio[0];
            if (b >= 0 && i - b == 5) force u_sat.cnt = 16'hFFF0;
            if (b >= 0 && i - b == 6) release u_sat.cnt;
        end
        checks += 4;
        if (nd != 1) begin errors++; $display("FAIL sat_done_pulses got=%0d want=1", nd); end
        if (r !== 16'hFFFF) begin errors++; $display("FAIL sat_result got=%h want=ffff", r); end
        if (o !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b want=1", o); end
        if (l !== 8'hBF) begin errors++; $display("FAIL sat_led got=%h want=bf", l); end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        sel = 4'd0;
        gpio = '0;
        s_start = 1'b0;
        s_sel = 4'd0;
        s_gpio = '0;
        test_reset();
        test_count();
        test_cont();
        test_ignore();
        test_reset_abort();
        test_parity();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
